// File: rtl/learn_pkg.sv
// Learning-mode sequencer shared types: FSM states, grade codes,
// note sentinels and the reaction-time grading helper.
package learn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    REST,
    PROMPT,
    HOLD,
    RELEASE,
    ADVANCE,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    GR_MISS = 3'd0,
    GR_C    = 3'd1,
    GR_B    = 3'd2,
    GR_A    = 3'd3,
    GR_S    = 3'd4
  } grade_t;

  localparam logic [3:0] NOTE_REST = 4'h0;
  localparam logic [3:0] NOTE_END  = 4'hF;

  // Reaction time t (in units) graded in steps of `step` units.
  function automatic grade_t grade_of(
    input int unsigned t,
    input int unsigned step
  );
    if (t < step)
      return GR_S;
    else if (t < 2 * step)
      return GR_A;
    else if (t < 3 * step)
      return GR_B;
    else
      return GR_C;
  endfunction

endpackage

// File: rtl/learn_sequencer_if.sv
// Song ROM bus: address/song out of the sequencer, note/duration back.
// master = sequencer, slave = ROM (combinational read).
interface learn_sequencer_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DUR_W  = 16
);

  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_song;
  logic [3:0]        rom_note;
  logic [DUR_W-1:0]  rom_dur;

  modport master (
    output rom_addr,
    output rom_song,
    input  rom_note,
    input  rom_dur
  );

  modport slave (
    input  rom_addr,
    input  rom_song,
    output rom_note,
    output rom_dur
  );

endinterface

// File: rtl/learn_sequencer_tick_prescaler.sv
// Free-running prescaler: tick pulses once every TICK_DIV clk cycles.
// Ports: clk, reset (async, active-low), clr (restart count), tick.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (clr || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  // A restart swallows any tick due in the same cycle.
  assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/learn_sequencer.sv
// Learning-mode controller: walks the song ROM, prompts each note,
// grades the reaction time, scores, and gates the buzzer.
// Ports: clk, reset (async low), start, abort, song_sel, rom bus,
//   key_note, show_note, tone_en/tone_note, grade/grade_valid,
//   score, busy, done.
module learn_sequencer
  import learn_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DUR_W     = 16,
  parameter int unsigned T_GRADE   = 500,
  parameter int unsigned T_TIMEOUT = 3000,
  parameter int unsigned SCORE_MAX = 99
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [3:0]         song_sel,
  learn_sequencer_if.master  rom,
  input  logic [3:0]         key_note,
  output logic [3:0]         show_note,
  output logic               tone_en,
  output logic [3:0]         tone_note,
  output logic [2:0]         grade,
  output logic               grade_valid,
  output logic [7:0]         score,
  output logic               busy,
  output logic               done
);

  localparam int unsigned RT_W = $clog2(T_TIMEOUT + 1);

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        song_q;
  logic [3:0]        note_q;
  logic [DUR_W-1:0]  dur_q;
  logic [RT_W-1:0]   rt_q;
  logic [DUR_W:0]    dcnt_q;
  logic [2:0]        grade_q;
  logic              gv_q;
  logic [7:0]        score_q;
  logic              key_prev;

  logic              tick;
  logic              accept;
  logic              key_press;
  logic              key_hit;
  logic              timeout;
  logic              dur_done;
  grade_t            hit_grade;
  logic [8:0]        sum_sc;
  logic [7:0]        score_nx;

  assign accept = start && !abort &&
                  (state == IDLE || state == DONE);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .tick  (tick)
  );

  assign key_press = (key_note != NOTE_REST) && !key_prev;
  assign key_hit   = key_press && (key_note == note_q);
  assign timeout   = rt_q >= RT_W'(T_TIMEOUT);

  // Exit on the tick that completes dur_q units; dur 0 exits on 1st.
  assign dur_done  = tick &&
                     ((dcnt_q + 1'b1) >= {1'b0, dur_q});

  assign hit_grade = grade_of({{(32-RT_W){1'b0}}, rt_q}, T_GRADE);
  assign sum_sc    = {1'b0, score_q} + {6'd0, hit_grade};
  assign score_nx  = (sum_sc > 9'(SCORE_MAX)) ?
                     8'(SCORE_MAX) : sum_sc[7:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    show_note = NOTE_REST;
    tone_en   = 1'b0;
    tone_note = NOTE_REST;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_n = FETCH;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (accept) state_n = FETCH;
      end
      FETCH: begin
        if (rom.rom_note == NOTE_END)
          state_n = DONE;
        else if (rom.rom_note == NOTE_REST)
          state_n = REST;
        else
          state_n = PROMPT;
      end
      REST: begin
        if (dur_done) state_n = ADVANCE;
      end
      PROMPT: begin
        show_note = note_q;
        if (key_hit)
          state_n = HOLD;
        else if (timeout && !key_press)
          state_n = ADVANCE;
      end
      HOLD: begin
        show_note = note_q;
        tone_en   = 1'b1;
        tone_note = note_q;
        if (dur_done || key_note == NOTE_REST)
          state_n = RELEASE;
      end
      RELEASE: begin
        if (key_note == NOTE_REST) state_n = ADVANCE;
      end
      ADVANCE: begin
        if (addr_q == '1)
          state_n = DONE;
        else
          state_n = FETCH;
      end
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      song_q   <= '0;
      note_q   <= '0;
      dur_q    <= '0;
      rt_q     <= '0;
      dcnt_q   <= '0;
      grade_q  <= '0;
      gv_q     <= 1'b0;
      score_q  <= '0;
      key_prev <= 1'b0;
    end else begin
      key_prev <= (key_note != NOTE_REST);
      gv_q     <= 1'b0;
      if (accept) begin
        addr_q  <= '0;
        song_q  <= song_sel;
        grade_q <= GR_MISS;
        score_q <= '0;
      end else if (!abort) begin
        case (state)
          FETCH: begin
            note_q <= rom.rom_note;
            dur_q  <= rom.rom_dur;
            rt_q   <= '0;
            dcnt_q <= '0;
          end
          REST: begin
            if (tick) dcnt_q <= dcnt_q + 1'b1;
          end
          PROMPT: begin
            if (tick && !timeout) rt_q <= rt_q + 1'b1;
            if (key_press) begin
              gv_q <= 1'b1;
              if (key_hit) begin
                grade_q <= hit_grade;
                score_q <= score_nx;
                dcnt_q  <= '0;
              end else begin
                grade_q <= GR_MISS;
              end
            end else if (timeout) begin
              gv_q    <= 1'b1;
              grade_q <= GR_MISS;
            end
          end
          HOLD: begin
            if (tick) dcnt_q <= dcnt_q + 1'b1;
          end
          ADVANCE: begin
            if (addr_q != '1) addr_q <= addr_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign rom.rom_addr = addr_q;
  assign rom.rom_song = song_q;
  assign grade        = grade_q;
  assign grade_valid  = gv_q;
  assign score        = score_q;

endmodule

// File: tb/tb_learn_sequencer.sv
// Directed bench for learn_sequencer with a small ROM model.
// TICK_DIV=4, T_GRADE=10, T_TIMEOUT=40.
module tb_learn_sequencer;
  import learn_pkg::*;

  localparam int unsigned TICK_DIV  = 4;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DUR_W     = 16;
  localparam int unsigned T_GRADE   = 10;
  localparam int unsigned T_TIMEOUT = 40;
  localparam int unsigned SCORE_MAX = 99;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] song_sel = '0;
  logic [3:0] key_note = '0;
  logic [3:0] show_note;
  logic       tone_en;
  logic [3:0] tone_note;
  logic [2:0] grade;
  logic       grade_valid;
  logic [7:0] score;
  logic       busy;
  logic       done;

  logic [3:0]  rom_n [32];
  logic [15:0] rom_d [32];

  int errors = 0;
  int checks = 0;
  int gv_cnt = 0;

  learn_sequencer_if #(.ADDR_W(ADDR_W), .DUR_W(DUR_W)) rom ();

  always_comb begin
    rom.rom_note = rom_n[rom.rom_addr];
    rom.rom_dur  = rom_d[rom.rom_addr];
  end

  learn_sequencer #(
    .TICK_DIV  (TICK_DIV),
    .ADDR_W    (ADDR_W),
    .DUR_W     (DUR_W),
    .T_GRADE   (T_GRADE),
    .T_TIMEOUT (T_TIMEOUT),
    .SCORE_MAX (SCORE_MAX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .song_sel    (song_sel),
    .rom         (rom.master),
    .key_note    (key_note),
    .show_note   (show_note),
    .tone_en     (tone_en),
    .tone_note   (tone_note),
    .grade       (grade),
    .grade_valid (grade_valid),
    .score       (score),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (grade_valid) gv_cnt <= gv_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_rom;
    for (int i = 0; i < 32; i++) begin
      rom_n[i] = NOTE_END;
      rom_d[i] = '0;
    end
  endtask

  task automatic do_start(input logic [3:0] s);
    @(negedge clk);
    song_sel = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_show(input logic [3:0] n);
    int k;
    k = 0;
    while (show_note !== n && k < 400) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (show_note !== n) begin
      errors++;
      $display("FAIL wait_show: show_note=%0d want %0d", show_note, n);
    end
  endtask

  task automatic press(input logic [3:0] n, input int t);
    repeat (4 * t) @(negedge clk);
    key_note = n;
    @(negedge clk);
  endtask

  task automatic test_reset;
    clear_rom();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({show_note, tone_en, tone_note, grade, grade_valid} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outs: got %h want 0",
               {show_note, tone_en, tone_note, grade, grade_valid});
    end
    checks++;
    if ({score, busy, done, rom.rom_addr, rom.rom_song} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0",
               {score, busy, done, rom.rom_addr, rom.rom_song});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: busy/done=%b want 00", {busy, done});
    end
  endtask

  task automatic test_s_hit;
    clear_rom();
    rom_n[0] = 4'd3;
    rom_d[0] = 16'd5;
    do_start(4'd2);
    checks++;
    if (rom.rom_song !== 4'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL s_start: song=%0d busy=%b want 2 1", rom.rom_song, busy);
    end
    wait_show(4'd3);
    checks++;
    if (tone_en !== 1'b0) begin
      errors++;
      $display("FAIL s_prompt_tone: tone_en=%b want 0", tone_en);
    end
    press(4'd3, 5);
    checks++;
    if (grade !== 3'd4 || grade_valid !== 1'b1 || score !== 8'd4) begin
      errors++;
      $display("FAIL s_grade: grade=%0d gv=%b score=%0d want 4 1 4",
               grade, grade_valid, score);
    end
    checks++;
    if (tone_en !== 1'b1 || tone_note !== 4'd3) begin
      errors++;
      $display("FAIL s_tone: tone_en=%b note=%0d want 1 3", tone_en, tone_note);
    end
    do_start(4'd7);
    repeat (8) @(negedge clk);
    checks++;
    if (tone_en !== 1'b1 || score !== 8'd4 || rom.rom_song !== 4'd2) begin
      errors++;
      $display("FAIL s_busy_start: tone=%b score=%0d song=%0d want 1 4 2",
               tone_en, score, rom.rom_song);
    end
    repeat (15) @(negedge clk);
    checks++;
    if (tone_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL s_hold_end: tone=%b busy=%b want 0 1", tone_en, busy);
    end
    key_note = 4'd0;
    repeat (5) @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || rom.rom_addr !== 5'd1) begin
      errors++;
      $display("FAIL s_done: done=%b busy=%b addr=%0d want 1 0 1",
               done, busy, rom.rom_addr);
    end
  endtask

  task automatic test_grades;
    clear_rom();
    rom_n[0] = 4'd3;
    rom_d[0] = 16'd2;
    rom_n[1] = 4'd6;
    rom_d[1] = 16'd2;
    do_start(4'd1);
    wait_show(4'd3);
    press(4'd3, 25);
    checks++;
    if (grade !== 3'd2 || grade_valid !== 1'b1 || score !== 8'd2) begin
      errors++;
      $display("FAIL grade_b: grade=%0d gv=%b score=%0d want 2 1 2",
               grade, grade_valid, score);
    end
    key_note = 4'd0;
    wait_show(4'd6);
    press(4'd6, 35);
    checks++;
    if (grade !== 3'd1 || grade_valid !== 1'b1 || score !== 8'd3) begin
      errors++;
      $display("FAIL grade_c: grade=%0d gv=%b score=%0d want 1 1 3",
               grade, grade_valid, score);
    end
    key_note = 4'd0;
    repeat (8) @(negedge clk);
    checks++;
    if (done !== 1'b1 || rom.rom_addr !== 5'd2) begin
      errors++;
      $display("FAIL grade_done: done=%b addr=%0d want 1 2", done, rom.rom_addr);
    end
  endtask

  task automatic test_wrong_retry;
    int g0;
    clear_rom();
    rom_n[0] = 4'd3;
    rom_d[0] = 16'd2;
    do_start(4'd0);
    wait_show(4'd3);
    g0 = gv_cnt;
    press(4'd5, 2);
    checks++;
    if (grade !== 3'd0 || grade_valid !== 1'b1 || score !== 8'd0) begin
      errors++;
      $display("FAIL wrong_grade: grade=%0d gv=%b score=%0d want 0 1 0",
               grade, grade_valid, score);
    end
    checks++;
    if (tone_en !== 1'b0 || show_note !== 4'd3) begin
      errors++;
      $display("FAIL wrong_stay: tone=%b show=%0d want 0 3", tone_en, show_note);
    end
    key_note = 4'd0;
    press(4'd3, 9);
    checks++;
    if (grade !== 3'd3 || grade_valid !== 1'b1 || score !== 8'd3) begin
      errors++;
      $display("FAIL retry_grade: grade=%0d gv=%b score=%0d want 3 1 3",
               grade, grade_valid, score);
    end
    checks++;
    if (tone_en !== 1'b1) begin
      errors++;
      $display("FAIL retry_tone: tone_en=%b want 1", tone_en);
    end
    key_note = 4'd0;
    repeat (5) @(negedge clk);
    checks++;
    if (gv_cnt - g0 !== 2 || done !== 1'b1) begin
      errors++;
      $display("FAIL retry_pulses: pulses=%0d done=%b want 2 1",
               gv_cnt - g0, done);
    end
  endtask

  task automatic test_timeout_rest;
    int g0;
    int k;
    clear_rom();
    rom_n[0] = 4'd2;
    rom_d[0] = 16'd1;
    rom_n[1] = 4'd3;
    rom_d[1] = 16'd2;
    rom_n[2] = 4'd0;
    rom_d[2] = 16'd6;
    rom_n[3] = 4'd4;
    rom_d[3] = 16'd2;
    do_start(4'd3);
    wait_show(4'd2);
    press(4'd2, 0);
    key_note = 4'd0;
    wait_show(4'd3);
    g0 = gv_cnt;
    repeat (156) @(negedge clk);
    checks++;
    if (gv_cnt !== g0 || show_note !== 4'd3) begin
      errors++;
      $display("FAIL to_early: pulses=%0d show=%0d want 0 3",
               gv_cnt - g0, show_note);
    end
    k = 0;
    while (grade_valid !== 1'b1 && k < 12) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (grade_valid !== 1'b1 || grade !== 3'd0 || score !== 8'd4) begin
      errors++;
      $display("FAIL to_grade: gv=%b grade=%0d score=%0d want 1 0 4",
               grade_valid, grade, score);
    end
    k = 0;
    while (show_note !== 4'd4 && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 12) begin
        checks++;
        if (rom.rom_addr !== 5'd2 || show_note !== 4'd0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL rest_mid: addr=%0d show=%0d busy=%b want 2 0 1",
                   rom.rom_addr, show_note, busy);
        end
      end
    end
    checks++;
    if (k < 25 || k > 28 || rom.rom_addr !== 5'd3) begin
      errors++;
      $display("FAIL rest_len: cycles=%0d addr=%0d want 25..28 3",
               k, rom.rom_addr);
    end
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || show_note !== 4'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b show=%0d done=%b want 0 0 0",
               busy, show_note, done);
    end
    checks++;
    if (score !== 8'd4 || grade !== 3'd0 || tone_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold: score=%0d grade=%0d tone=%b want 4 0 0",
               score, grade, tone_en);
    end
  endtask

  task automatic test_saturate;
    int exp_sc;
    int exp_gr;
    logic [3:0] n;
    clear_rom();
    for (int i = 0; i < 26; i++) begin
      rom_n[i] = 4'((i % 7) + 1);
      rom_d[i] = 16'd1;
    end
    exp_sc = 0;
    do_start(4'd5);
    for (int i = 0; i < 26; i++) begin
      n = rom_n[i];
      wait_show(n);
      exp_gr = (i == 24) ? 2 : 4;
      press(n, (i == 24) ? 22 : 0);
      exp_sc = exp_sc + exp_gr;
      if (exp_sc > 99) exp_sc = 99;
      checks++;
      if (grade !== 3'(exp_gr) || score !== 8'(exp_sc)) begin
        errors++;
        $display("FAIL sat_step%0d: grade=%0d score=%0d want %0d %0d",
                 i, grade, score, exp_gr, exp_sc);
      end
      key_note = 4'd0;
    end
    repeat (8) @(negedge clk);
    checks++;
    if (score !== 8'd99 || done !== 1'b1) begin
      errors++;
      $display("FAIL sat_final: score=%0d done=%b want 99 1", score, done);
    end
    do_start(4'd5);
    checks++;
    if (score !== 8'd0 || grade !== 3'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear: score=%0d grade=%0d done=%b want 0 0 0",
               score, grade, done);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_reset_hold;
    clear_rom();
    rom_n[0] = 4'd3;
    rom_d[0] = 16'd50;
    do_start(4'd1);
    wait_show(4'd3);
    press(4'd3, 1);
    checks++;
    if (tone_en !== 1'b1 || score !== 8'd4) begin
      errors++;
      $display("FAIL rh_hold: tone=%b score=%0d want 1 4", tone_en, score);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({tone_en, tone_note, show_note, grade, grade_valid} !== 13'd0) begin
      errors++;
      $display("FAIL rh_async_outs: got %h want 0",
               {tone_en, tone_note, show_note, grade, grade_valid});
    end
    checks++;
    if ({score, busy, done, rom.rom_addr} !== 15'd0) begin
      errors++;
      $display("FAIL rh_async_state: got %h want 0",
               {score, busy, done, rom.rom_addr});
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || tone_en !== 1'b0) begin
      errors++;
      $display("FAIL rh_idle: busy=%b done=%b tone=%b want 0 0 0",
               busy, done, tone_en);
    end
    key_note = 4'd0;
  endtask

  initial begin
    test_reset();
    test_s_hit();
    test_grades();
    test_wrong_retry();
    test_timeout_rest();
    test_saturate();
    test_reset_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
